// File: rtl/vx_commit_arbiter.sv
// vx_commit_arbiter
// Merges the per-unit commit streams of one issue slot into a single
// registered writeback/commit port.
//
// Requester order: 0=ALU, 1=LSU, 2=FPU, 3=SFU, 4=TCU.
// Requesters are served round-robin. A multi-beat packet (sop..eop) locks the
// arbiter to its requester until the eop beat transfers. The output register
// gives 1-cycle latency at full throughput.
//
// Ports:
//   clk          core clock
//   reset        asynchronous, active-low reset
//   in_valid     per-requester commit valid
//   in_data      per-requester payload, requester i at [i*DATA_W +: DATA_W]
//   in_eop       per-requester last beat of packet
//   in_ready     per-requester accept (combinational, depends on out_ready)
//   out_valid    merged commit valid (registered)
//   out_data     merged payload (registered)
//   out_eop      eop of the registered beat
//   out_sel      index of the requester that produced the registered beat
//   out_ready    downstream accept
//   perf_stalls  cycles with out_valid=1 and out_ready=0
//   perf_grants  beats accepted per requester, requester i at [i*PERF_W +: PERF_W]
//
// Optional feature: define COMMIT_ARB_PERF_EN to build the performance
// counters. When undefined the perf ports stay present but are tied to 0.

module vx_commit_arbiter #(
    parameter int NUM_REQS = 5,
    parameter int DATA_W   = 128,
    parameter int PERF_W   = 32,
    localparam int SEL_W   = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          in_valid,
    input  logic [NUM_REQS*DATA_W-1:0]   in_data,
    input  logic [NUM_REQS-1:0]          in_eop,
    output logic [NUM_REQS-1:0]          in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_eop,
    output logic [SEL_W-1:0]             out_sel,
    input  logic                         out_ready,
    output logic [PERF_W-1:0]            perf_stalls,
    output logic [NUM_REQS*PERF_W-1:0]   perf_grants
);

    logic [NUM_REQS-1:0] eligible;
    logic [NUM_REQS-1:0] req;
    logic [NUM_REQS-1:0] grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [DATA_W-1:0]   grant_data;
    logic                grant_eop;
    logic                any_req;
    logic                load_en;

    logic [SEL_W-1:0]    rr_ptr;
    logic                lock;
    logic [SEL_W-1:0]    lock_idx;

    // While a packet is open only its owner may compete, so beats of
    // different packets can never interleave on the commit port.
    always_comb begin
        eligible = '1;
        if (lock) begin
            eligible           = '0;
            eligible[lock_idx] = 1'b1;
        end
    end

    assign req = in_valid & eligible;

    // Scan from rr_ptr upward with wrap; the first requesting index wins.
    always_comb begin : grant_scan
        int  idx;
        logic found;
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
        grant_eop  = 1'b0;
        found      = 1'b0;
        idx        = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQS) begin
                idx = idx - NUM_REQS;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SEL_W'(idx);
                grant_data = in_data[idx*DATA_W +: DATA_W];
                grant_eop  = in_eop[idx];
            end
        end
        any_req = found;
    end

    // The output register can take a new beat when it is empty or being
    // drained this cycle, which gives full throughput without a skid buffer.
    assign load_en  = (!out_valid || out_ready) && any_req;
    assign in_ready = load_en ? grant : '0;

    // Output register plus arbitration state. An eop beat releases the lock
    // and moves priority past the winner; a non-eop beat pins the winner.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eop   <= 1'b0;
            out_sel   <= '0;
            rr_ptr    <= '0;
            lock      <= 1'b0;
            lock_idx  <= '0;
        end else begin
            if (load_en) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_eop   <= grant_eop;
                out_sel   <= grant_idx;
                if (grant_eop) begin
                    lock   <= 1'b0;
                    rr_ptr <= (grant_idx == SEL_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
                end else begin
                    lock     <= 1'b1;
                    lock_idx <= grant_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef COMMIT_ARB_PERF_EN
    logic [PERF_W-1:0] stall_cnt;
    logic [PERF_W-1:0] grant_cnt [NUM_REQS];

    // Stall counter: downstream held off a valid beat this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // Per-requester accepted-beat counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                grant_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (in_valid[i] && in_ready[i]) begin
                    grant_cnt[i] <= grant_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign perf_stalls = stall_cnt;
    for (genvar g = 0; g < NUM_REQS; g++) begin : g_perf
        assign perf_grants[g*PERF_W +: PERF_W] = grant_cnt[g];
    end
`else
    assign perf_stalls = '0;
    assign perf_grants = '0;
`endif

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// tb_vx_commit_arbiter
// Directed plus randomized bench for vx_commit_arbiter. A behavioural model
// tracks the expected output register, round-robin position, packet lock and
// perf counts, and every cycle is compared against the DUT.
// Define COMMIT_ARB_PERF_EN for both files to exercise the counters.

module tb_vx_commit_arbiter;

    localparam int N  = 5;
    localparam int DW = 128;
    localparam int PW = 32;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_eop;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_eop;
    logic [SW-1:0]   out_sel;
    logic            out_ready;
    logic [PW-1:0]   perf_stalls;
    logic [N*PW-1:0] perf_grants;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit            m_valid;
    logic [DW-1:0] m_data;
    bit            m_eop;
    int            m_sel;
    int            m_rr;
    bit            m_lock;
    int            m_owner;
    int            m_stalls;
    int            m_grants [N];

    logic [N-1:0]  obs_ready;
    logic [PW-1:0] saved_stalls;
    logic [DW-1:0] saved_data;

    vx_commit_arbiter #(.NUM_REQS(N), .DATA_W(DW), .PERF_W(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_eop      (in_eop),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_eop     (out_eop),
        .out_sel     (out_sel),
        .out_ready   (out_ready),
        .perf_stalls (perf_stalls),
        .perf_grants (perf_grants)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 0;
        m_data   = '0;
        m_eop    = 0;
        m_sel    = 0;
        m_rr     = 0;
        m_lock   = 0;
        m_owner  = 0;
        m_stalls = 0;
        for (int i = 0; i < N; i++) m_grants[i] = 0;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] v, input logic [N-1:0] e, input logic r);
        in_valid  = v;
        in_eop    = e;
        out_ready = r;
        for (int i = 0; i < N*DW/32; i++) in_data[i*32 +: 32] = $urandom;
    endtask

    function automatic int exp_perf(input int v);
`ifdef COMMIT_ARB_PERF_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // One clock cycle: called at posedge+1, compares mid-cycle, advances the
    // model across the edge and returns at the next posedge+1.
    task automatic check_output(input string tag);
        logic [N-1:0]  exp_ready;
        logic [DW-1:0] d;
        bit found, can_load, e, r;
        int g;
        #3;
        found    = 0;
        g        = 0;
        can_load = !m_valid || out_ready;
        for (int off = 0; off < N; off++) begin
            int k;
            k = (m_rr + off) % N;
            if (!found && in_valid[k] && (!m_lock || k == m_owner)) begin
                found = 1;
                g     = k;
            end
        end
        exp_ready = '0;
        if (found && can_load) exp_ready[g] = 1'b1;
        obs_ready = in_ready;
        chk({tag, "/in_ready"},  in_ready,  exp_ready);
        chk({tag, "/out_valid"}, out_valid, m_valid);
        chk({tag, "/out_sel"},   out_sel,   m_sel);
        chk({tag, "/out_eop"},   out_eop,   m_eop);
        chk({tag, "/out_data"},  out_data,  m_data);
        chk({tag, "/perf_stalls"}, perf_stalls, 32'(exp_perf(m_stalls)));
        for (int i = 0; i < N; i++)
            chk({tag, "/perf_grants"}, perf_grants[i*PW +: PW], 32'(exp_perf(m_grants[i])));
        d = in_data[g*DW +: DW];
        e = in_eop[g];
        r = out_ready;
        @(posedge clk);
        #1;
        if (m_valid && !r) m_stalls++;
        if (found && can_load) begin
            m_valid = 1;
            m_data  = d;
            m_eop   = e;
            m_sel   = g;
            m_grants[g]++;
            if (e) begin
                m_lock = 0;
                m_rr   = (g + 1) % N;
            end else begin
                m_lock  = 1;
                m_owner = g;
            end
        end else if (r) begin
            m_valid = 0;
        end
    endtask

    initial begin
        logic [N-1:0] fair_seq [3];
        fair_seq[0] = 5'b00001;
        fair_seq[1] = 5'b00010;
        fair_seq[2] = 5'b10000;

        // Reset state
        reset = 1'b0;
        model_reset();
        apply_stimulus('0, '0, 1'b1);
        #12;
        chk("reset/out_valid", out_valid, 1'b0);
        chk("reset/out_data", out_data, '0);
        chk("reset/out_sel", out_sel, '0);
        chk("reset/in_ready", in_ready, '0);
        chk("reset/perf_stalls", perf_stalls, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Back-to-back single-beat commits from req 2
        for (int c = 0; c < 4; c++) begin
            apply_stimulus(5'b00100, 5'b11111, 1'b1);
            check_output("b2b");
            chk("b2b/ready2", obs_ready, 5'b00100);
            chk("b2b/sel", out_sel, 3'd2);
            chk("b2b/valid", out_valid, 1'b1);
        end
        // Priority now starts at 3: req 4 must beat req 1
        apply_stimulus(5'b10010, 5'b11111, 1'b1);
        check_output("rrptr");
        chk("rrptr/ready", obs_ready, 5'b10000);
        apply_stimulus('0, '0, 1'b1);
        check_output("drain");

        // Round-robin fairness over reqs 0,1,4
        for (int c = 0; c < 6; c++) begin
            apply_stimulus(5'b10011, 5'b11111, 1'b1);
            check_output("fair");
            chk("fair/ready", obs_ready, fair_seq[c % 3]);
        end
        apply_stimulus('0, '0, 1'b1);
        check_output("drain");
        chk("fair/grants0", perf_grants[0*PW +: PW], 32'(exp_perf(2)));
        chk("fair/grants1", perf_grants[1*PW +: PW], 32'(exp_perf(2)));

        // Packet lock: req 1 three beats while req 0 waits
        apply_stimulus(5'b00010, 5'b00000, 1'b1);
        check_output("lock");
        chk("lock/ready_b1", obs_ready, 5'b00010);
        apply_stimulus(5'b00011, 5'b00001, 1'b1);
        check_output("lock");
        chk("lock/ready_b2", obs_ready, 5'b00010);
        apply_stimulus(5'b00011, 5'b00011, 1'b1);
        check_output("lock");
        chk("lock/ready_b3", obs_ready, 5'b00010);
        chk("lock/sel_b3", out_sel, 3'd1);
        apply_stimulus(5'b00001, 5'b00001, 1'b1);
        check_output("lock");
        chk("lock/ready_after", obs_ready, 5'b00001);
        chk("lock/sel_after", out_sel, 3'd0);
        apply_stimulus('0, '0, 1'b1);
        check_output("drain");

        // Backpressure with reqs 0 and 3 valid
        apply_stimulus(5'b01001, 5'b11111, 1'b1);
        check_output("bp");
        chk("bp/first", obs_ready, 5'b01000);
        saved_data   = out_data;
        saved_stalls = perf_stalls;
        for (int c = 0; c < 5; c++) begin
            apply_stimulus(5'b01001, 5'b11111, 1'b0);
            check_output("bp");
            chk("bp/ready_zero", obs_ready, 5'b00000);
            chk("bp/data_hold", out_data, saved_data);
        end
        chk("bp/stalls5", perf_stalls - saved_stalls, 32'(exp_perf(5)));
        apply_stimulus(5'b01001, 5'b11111, 1'b1);
        check_output("bp");
        chk("bp/resume", obs_ready, 5'b00001);
        apply_stimulus(5'b01001, 5'b11111, 1'b1);
        check_output("bp");
        chk("bp/resume2", obs_ready, 5'b01000);
        apply_stimulus('0, '0, 1'b1);
        check_output("drain");

        // Locked bubble: req 3 opens a packet then goes quiet
        apply_stimulus(5'b01000, 5'b00000, 1'b1);
        check_output("bubble");
        chk("bubble/open", obs_ready, 5'b01000);
        for (int c = 0; c < 2; c++) begin
            apply_stimulus(5'b00001, 5'b00001, 1'b1);
            check_output("bubble");
            chk("bubble/blocked", obs_ready, 5'b00000);
            chk("bubble/gap_valid", out_valid, 1'b0);
        end
        apply_stimulus(5'b01001, 5'b01001, 1'b1);
        check_output("bubble");
        chk("bubble/eop_sel", out_sel, 3'd3);
        apply_stimulus(5'b00001, 5'b00001, 1'b1);
        check_output("bubble");
        chk("bubble/next_sel", out_sel, 3'd0);
        apply_stimulus('0, '0, 1'b1);
        check_output("drain");

        // Asynchronous reset while req 1 holds the lock
        apply_stimulus(5'b00010, 5'b00000, 1'b1);
        check_output("areset");
        #2;
        reset = 1'b0;
        #1;
        chk("areset/out_valid", out_valid, 1'b0);
        chk("areset/out_data", out_data, '0);
        chk("areset/out_eop", out_eop, 1'b0);
        model_reset();
        apply_stimulus(5'b00101, 5'b11111, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_output("areset");
        chk("areset/first_grant", obs_ready, 5'b00001);
        chk("areset/perf_stalls", perf_stalls, '0);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            apply_stimulus(N'($urandom), N'($urandom), ($urandom_range(0, 3) != 0));
            check_output("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
